// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: rising-edge write strobe -> byte FIFO -> 8N1 serialiser.
// Defining UART_TX_PARITY_EN adds an even-parity bit (8E1 frames, 11 bits).
module uart_tx_buf #(
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_uart,
  input  logic       rst_n,
  input  logic       uart_wrsig,
  input  logic [7:0] uart_datain,
  output logic       tx,
  output logic       tx_idle,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            wr_q;
  logic            ovf_q;
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic wr_req, fifo_full, fifo_empty, push, pop, tick_end;

  assign wr_req     = uart_wrsig & ~wr_q;
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  // A full FIFO rejects the write even when a pop frees a slot in the same cycle.
  assign push       = wr_req & ~fifo_full;
  assign tick_end   = (tick_q == TICK_LAST);

  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wr_q  <= uart_wrsig;
      ovf_q <= wr_req & fifo_full;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_uart) begin
    if (push) fifo_q[wptr_q] <= uart_datain;
  end

  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = fifo_q[rptr_q];
          tick_d   = '0;
          bit_d    = '0;
          state_d  = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_q[rptr_q];
`endif
        end
      end
      S_START: begin
        if (tick_end) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_DATA: begin
        if (tick_end) begin
          tick_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick_end) begin
          tick_d  = '0;
          state_d = S_STOP;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
`endif
      S_STOP: begin
        if (tick_end) begin
          tick_d  = '0;
          state_d = S_IDLE;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The line level is derived from the next state so tx stays a pure flop output.
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign tx_idle  = (state_q == S_IDLE) && fifo_empty;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_buf: stimulus queues expected bytes, a line monitor
// decodes every frame on tx and compares it with the head of that queue.
module tb_uart_tx_buf;

  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBIT = 11;
`else
  localparam int NBIT = 10;
`endif

  logic       clk_uart = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_wrsig = 1'b0;
  logic [7:0] uart_datain = 8'h00;
  logic       tx, tx_idle, overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  int         gap_q[$];
  int         mon_gap = -1;
  int         mon_frames = 0;
  int         ovf_cycles = 0;
  logic       mon_busy = 1'b0;
  int         mon_cnt = 0;
  logic       mon_ok = 1'b1;
  logic [NBIT-1:0] mon_bits = '0;

  uart_tx_buf dut (
    .clk_uart   (clk_uart),
    .rst_n      (rst_n),
    .uart_wrsig (uart_wrsig),
    .uart_datain(uart_datain),
    .tx         (tx),
    .tx_idle    (tx_idle),
    .overflow   (overflow)
  );

  always #5 clk_uart = ~clk_uart;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic frame_done();
    logic [31:0] got, want;
    logic [7:0]  b;
    mon_frames++;
    got = '0;
    for (int i = 0; i < NBIT; i++) got[i] = mon_bits[i];
    got[NBIT] = mon_ok;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_frame: got frame bits 0x%0h, expected no frame", got);
    end else begin
      b = exp_q.pop_front();
      want = '0;
      want[8:1] = b;
`ifdef UART_TX_PARITY_EN
      want[9] = ^b;
`endif
      want[NBIT-1] = 1'b1;
      want[NBIT]   = 1'b1;
      check("frame", got, want);
    end
  endtask

  // Line monitor: each bit must hold for exactly OS cycles; mon_bits[0] is the start bit.
  always @(negedge clk_uart) begin
    if (overflow === 1'b1) ovf_cycles++;
    if (!rst_n) begin
      mon_busy = 1'b0;
      mon_gap  = -1;
    end else begin
      if (!mon_busy) begin
        if (tx === 1'b0) begin
          mon_busy = 1'b1;
          mon_cnt  = 0;
          mon_ok   = 1'b1;
          if (mon_gap >= 0) gap_q.push_back(mon_gap);
        end else if (mon_gap >= 0) begin
          mon_gap++;
        end
      end
      if (mon_busy) begin
        if (mon_cnt % OS == 0) mon_bits[mon_cnt / OS] = tx;
        else if (tx !== mon_bits[mon_cnt / OS]) mon_ok = 1'b0;
        mon_cnt++;
        if (mon_cnt == NBIT * OS) begin
          mon_busy = 1'b0;
          mon_gap  = 0;
          frame_done();
        end
      end
    end
  end

  // Caller sits on a negedge; returns on a negedge with the strobe low again.
  task automatic strobe(input logic [7:0] d, input int hold);
    uart_wrsig  = 1'b1;
    uart_datain = d;
    repeat (hold) @(negedge clk_uart);
    uart_wrsig = 1'b0;
    @(negedge clk_uart);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c;
    c = 0;
    while (tx_idle !== 1'b1 && c < budget) begin
      @(negedge clk_uart);
      c++;
    end
    check(name, tx_idle, 1);
  endtask

  task automatic reset_gaps();
    @(posedge clk_uart);
    #1;
    mon_gap = -1;
    gap_q.delete();
    @(negedge clk_uart);
  endtask

  function automatic int count_ones_gaps();
    int n;
    n = 0;
    foreach (gap_q[i]) if (gap_q[i] == 1) n++;
    return n;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, f0, o0;

    // Reset state
    repeat (3) @(negedge clk_uart);
    #1;
    check("rst_tx", tx, 1);
    check("rst_tx_idle", tx_idle, 1);
    check("rst_overflow", overflow, 0);
    @(negedge clk_uart);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_uart);

    // Single byte 0x31: latency and frame length
    exp_q.push_back(8'h31);
    uart_wrsig  = 1'b1;
    uart_datain = 8'h31;
    @(posedge clk_uart);
    #1;
    check("idle_falls_at_write", tx_idle, 0);
    check("tx_high_at_write", tx, 1);
    @(negedge clk_uart);
    uart_wrsig = 1'b0;
    @(posedge clk_uart);
    #1;
    check("start_latency", tx, 0);
    cyc = 1;
    while (tx_idle !== 1'b1 && cyc < 400) begin
      @(posedge clk_uart);
      #1;
      cyc++;
    end
    check("idle_return_cycles", cyc, 1 + NBIT * OS);
    @(negedge clk_uart);
    check("single_drained", exp_q.size(), 0);

    // Level-held strobe: one frame only
    f0 = mon_frames;
    o0 = ovf_cycles;
    exp_q.push_back(8'h32);
    strobe(8'h32, 5);
    wait_idle(400, "held_idle_timeout");
    repeat (200) @(negedge clk_uart);
    check("held_frames", mon_frames - f0, 1);
    check("held_no_overflow", ovf_cycles - o0, 0);
    check("held_drained", exp_q.size(), 0);

    // Burst of six: fifth fills the FIFO, sixth is dropped
    reset_gaps();
    f0 = mon_frames;
    o0 = ovf_cycles;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h31 + 8'(i));
      strobe(8'h31 + 8'(i), 1);
    end
    uart_wrsig  = 1'b1;
    uart_datain = 8'h36;
    @(posedge clk_uart);
    #1;
    check("overflow_pulse", overflow, 1);
    @(negedge clk_uart);
    uart_wrsig = 1'b0;
    @(posedge clk_uart);
    #1;
    check("overflow_width", overflow, 0);
    @(negedge clk_uart);
    wait_idle(5 * (NBIT * OS + 2) + 50, "burst_idle_timeout");
    repeat (5) @(negedge clk_uart);
    check("burst_frames", mon_frames - f0, 5);
    check("burst_overflow_cycles", ovf_cycles - o0, 1);
    check("burst_drained", exp_q.size(), 0);
    check("burst_gap_count", gap_q.size(), 4);
    check("burst_gaps_one", count_ones_gaps(), 4);

    // Write landing on the IDLE pop cycle of a queued byte
    reset_gaps();
    f0 = mon_frames;
    o0 = ovf_cycles;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'hC3);
    uart_wrsig  = 1'b1;
    uart_datain = 8'h41;
    @(negedge clk_uart);
    uart_wrsig = 1'b0;
    @(negedge clk_uart);
    uart_wrsig  = 1'b1;
    uart_datain = 8'h42;
    @(negedge clk_uart);
    uart_wrsig = 1'b0;
    repeat (159) @(negedge clk_uart);
    check("pop_slot_tx_idle_level", tx, 1);
    check("pop_slot_busy", tx_idle, 0);
    uart_wrsig  = 1'b1;
    uart_datain = 8'hC3;
    @(negedge clk_uart);
    uart_wrsig = 1'b0;
    wait_idle(3 * (NBIT * OS + 2) + 50, "simul_idle_timeout");
    repeat (5) @(negedge clk_uart);
    check("simul_frames", mon_frames - f0, 3);
    check("simul_drained", exp_q.size(), 0);
    check("simul_gaps_one", count_ones_gaps(), 2);
    check("simul_no_overflow", ovf_cycles - o0, 0);

    // Reset during DATA bit 3 of 0x51 with two bytes queued
    exp_q.push_back(8'h51);
    exp_q.push_back(8'h52);
    exp_q.push_back(8'h53);
    strobe(8'h51, 1);
    strobe(8'h52, 1);
    strobe(8'h53, 1);
    repeat (68) @(negedge clk_uart);
    check("mid_frame_bit3", tx, 0);
    check("mid_frame_busy", tx_idle, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_tx_idle", tx_idle, 1);
    exp_q.delete();
    f0 = mon_frames;
    repeat (3) @(negedge clk_uart);
    rst_n = 1'b1;
    repeat (300) @(negedge clk_uart);
    check("post_rst_frames", mon_frames - f0, 0);
    check("post_rst_tx", tx, 1);
    check("post_rst_tx_idle", tx_idle, 1);

`ifdef UART_TX_PARITY_EN
    // Parity bit values sampled mid-bit: 0x31 -> 1, 0x33 -> 0
    f0 = mon_frames;
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h33);
    strobe(8'h31, 1);
    repeat (149) @(negedge clk_uart);
    check("parity_0x31", tx, 1);
    strobe(8'h33, 1);
    repeat (178) @(negedge clk_uart);
    check("parity_0x33", tx, 0);
    wait_idle(400, "parity_idle_timeout");
    repeat (5) @(negedge clk_uart);
    check("parity_frames", mon_frames - f0, 2);
    check("parity_drained", exp_q.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
